// File: rtl/divider.sv
// 32-bit signed/unsigned restoring divider with a four-state control FSM.
// Fixed latency: done_o is high in the cycle after the 34th edge counted from the accept edge (1 accept + 32 CALC + 1 FIX).
// No backpressure: start_i is only sampled in IDLE and is ignored while busy; nothing is queued.
module divider (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        div_zero_o,
  output logic        zero_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // dq_q starts as the dividend magnitude; its MSBs are consumed while
  // quotient bits shift in at the LSB, so after 32 steps it holds the quotient.
  logic [31:0] dq_q, dq_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] src1_q, src1_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] remo_q, remo_d;
  logic        dz_q, dz_d;
  logic        zero_q, zero_d;

  // Operand sign/magnitude at acceptance; unsigned mode never sees a sign.
  logic        sign1, sign2;
  logic [31:0] mag1, mag2;
  assign sign1 = signed_i & src1_i[31];
  assign sign2 = signed_i & src2_i[31];
  assign mag1  = sign1 ? (~src1_i + 32'd1) : src1_i;
  assign mag2  = sign2 ? (~src2_i + 32'd1) : src2_i;

  // One restoring step: the partial remainder is always below the divisor,
  // so 33 bits are enough for the shifted value and its difference.
  logic [32:0] rem_shift, diff;
  assign rem_shift = {rem_q, dq_q[31]};
  assign diff      = rem_shift - {1'b0, dsr_q};

  // Sign fix-up; a zero divisor overrides with the all-ones quotient and
  // the dividend exactly as it was presented.
  logic [31:0] quo_fix, rem_fix;
  assign quo_fix = div0_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~dq_q + 32'd1) : dq_q);
  assign rem_fix = div0_q ? src1_q : (neg_rem_q ? (~rem_q + 32'd1) : rem_q);

  // Next-state and datapath updates for each control state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    src1_d    = src1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dz_d      = dz_q;
    zero_d    = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dq_d      = mag1;
          dsr_d     = mag2;
          rem_d     = 32'd0;
          cnt_d     = 6'd0;
          src1_d    = src1_i;
          neg_quo_d = sign1 ^ sign2;
          neg_rem_d = sign1;
          div0_d    = (src2_i == 32'd0);
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = diff[32] ? rem_shift[31:0] : diff[31:0];
        dq_d  = {dq_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quot_d  = quo_fix;
        remo_d  = rem_fix;
        dz_d    = div0_q;
        zero_d  = (quo_fix == 32'd0);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q     <= 6'd0;
      dq_q      <= 32'd0;
      rem_q     <= 32'd0;
      dsr_q     <= 32'd0;
      src1_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      quot_q    <= 32'd0;
      remo_q    <= 32'd0;
      dz_q      <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      src1_q    <= src1_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      dz_q      <= dz_d;
      zero_q    <= zero_d;
    end
  end

  assign busy_o      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o      = (state_q == S_DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = remo_q;
  assign div_zero_o  = dz_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: reset, unsigned/signed results, divide by zero,
// overflow, ignored starts and mid-operation reset; outputs sampled on negedge.
module tb_divider;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] src1_i = 32'd0;
  logic [31:0] src2_i = 32'd0;
  logic        busy_o, done_o, div_zero_o, zero_o;
  logic [31:0] quotient_o, remainder_o;

  int n_cmp  = 0;
  int n_fail = 0;

  divider dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o),
    .div_zero_o (div_zero_o),
    .zero_o     (zero_o)
  );

  always #5 clk_i = ~clk_i;

  // Present one start for a single edge (edge 0), then scramble the operand
  // inputs so a design that fails to capture them gives a wrong answer.
  task automatic do_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i  = 1'b1;
    signed_i = sgn;
    src1_i   = a;
    src2_i   = b;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i  = 1'b0;
    signed_i = ~sgn;
    src1_i   = ~a;
    src2_i   = b ^ 32'h0000_0013;
  endtask

  // Called at the negedge after edge 0; returns the edge index after which
  // done_o was first seen and how many sampled cycles had busy_o high.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = busy_o ? 1 : 0;
    while (!done_o && lat < 60) begin
      @(posedge clk_i);
      @(negedge clk_i);
      lat++;
      if (busy_o) busy_n++;
    end
  endtask

  task automatic test_reset;
    rst_i   = 1'b0;
    start_i = 1'b1;
    src1_i  = 32'd100;
    src2_i  = 32'd7;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
    n_cmp++; if (quotient_o !== 32'd0) begin n_fail++; $display("FAIL reset_quot got=%h exp=0", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd0) begin n_fail++; $display("FAIL reset_rem got=%h exp=0", remainder_o); end
    n_cmp++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b exp=0", div_zero_o); end
    n_cmp++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", zero_o); end
    rst_i   = 1'b1;
    start_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored busy=%b exp=0", busy_o); end
  endtask

  task automatic test_unsigned_basic;
    int lat, bn;
    do_start(1'b0, 32'd100, 32'd7);
    wait_done(lat, bn);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL u100_7_latency got=%0d exp=33", lat); end
    n_cmp++; if (bn !== 33) begin n_fail++; $display("FAIL u100_7_busy_cycles got=%0d exp=33", bn); end
    n_cmp++; if (quotient_o !== 32'd14) begin n_fail++; $display("FAIL u100_7_quot got=%h exp=e", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd2) begin n_fail++; $display("FAIL u100_7_rem got=%h exp=2", remainder_o); end
    n_cmp++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL u100_7_zero got=%b exp=0", zero_o); end
    n_cmp++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL u100_7_dz got=%b exp=0", div_zero_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL u100_7_done_pulse got=%b exp=0", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL u100_7_idle_busy got=%b exp=0", busy_o); end
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (quotient_o !== 32'd14) begin n_fail++; $display("FAIL u100_7_hold_quot got=%h exp=e", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd2) begin n_fail++; $display("FAIL u100_7_hold_rem got=%h exp=2", remainder_o); end
  endtask

  task automatic test_signed;
    int lat, bn;
    do_start(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(lat, bn);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL s_m7_2_latency got=%0d exp=33", lat); end
    n_cmp++; if (quotient_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL s_m7_2_quot got=%h exp=fffffffd", quotient_o); end
    n_cmp++; if (remainder_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL s_m7_2_rem got=%h exp=ffffffff", remainder_o); end
    do_start(1'b0, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(lat, bn);
    n_cmp++; if (quotient_o !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL u_fff9_2_quot got=%h exp=7ffffffc", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd1) begin n_fail++; $display("FAIL u_fff9_2_rem got=%h exp=1", remainder_o); end
    do_start(1'b1, 32'd20, 32'hFFFF_FFFA);
    wait_done(lat, bn);
    n_cmp++; if (quotient_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL s_20_m6_quot got=%h exp=fffffffd", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd2) begin n_fail++; $display("FAIL s_20_m6_rem got=%h exp=2", remainder_o); end
  endtask

  task automatic test_div_zero;
    int lat, bn;
    for (int m = 0; m < 2; m++) begin
      do_start(m[0], 32'd5, 32'd0);
      wait_done(lat, bn);
      n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL dz_latency mode=%0d got=%0d exp=33", m, lat); end
      n_cmp++; if (quotient_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_quot mode=%0d got=%h exp=ffffffff", m, quotient_o); end
      n_cmp++; if (remainder_o !== 32'd5) begin n_fail++; $display("FAIL dz_rem mode=%0d got=%h exp=5", m, remainder_o); end
      n_cmp++; if (div_zero_o !== 1'b1) begin n_fail++; $display("FAIL dz_flag mode=%0d got=%b exp=1", m, div_zero_o); end
      n_cmp++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL dz_zero mode=%0d got=%b exp=0", m, zero_o); end
    end
    do_start(1'b0, 32'd3, 32'd5);
    wait_done(lat, bn);
    n_cmp++; if (quotient_o !== 32'd0) begin n_fail++; $display("FAIL u3_5_quot got=%h exp=0", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd3) begin n_fail++; $display("FAIL u3_5_rem got=%h exp=3", remainder_o); end
    n_cmp++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL u3_5_zero got=%b exp=1", zero_o); end
    n_cmp++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL u3_5_dz got=%b exp=0", div_zero_o); end
  endtask

  task automatic test_overflow;
    int lat, bn;
    do_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bn);
    n_cmp++; if (quotient_o !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_quot got=%h exp=80000000", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd0) begin n_fail++; $display("FAIL ovf_rem got=%h exp=0", remainder_o); end
    n_cmp++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL ovf_dz got=%b exp=0", div_zero_o); end
  endtask

  task automatic test_back_to_back_start;
    int done_cnt;
    int done_edge;
    done_cnt  = 0;
    done_edge = -1;
    do_start(1'b0, 32'd100, 32'd7);
    for (int e = 1; e <= 40; e++) begin
      start_i  = (e == 5 || e == 33);
      signed_i = 1'b1;
      src1_i   = 32'd50 + 32'(e);
      src2_i   = 32'd3;
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) begin
        done_cnt++;
        done_edge = e;
      end
    end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
    n_cmp++; if (done_edge !== 33) begin n_fail++; $display("FAIL ignore_done_edge got=%0d exp=33", done_edge); end
    n_cmp++; if (quotient_o !== 32'd14) begin n_fail++; $display("FAIL ignore_quot got=%h exp=e", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd2) begin n_fail++; $display("FAIL ignore_rem got=%h exp=2", remainder_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after got=%b exp=0", busy_o); end
  endtask

  task automatic test_reset_abort;
    int lat, bn, done_cnt;
    done_cnt = 0;
    do_start(1'b0, 32'd100, 32'd7);
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got=%b exp=1", busy_o); end
    rst_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    n_cmp++; if (quotient_o !== 32'd0) begin n_fail++; $display("FAIL abort_quot got=%h exp=0", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd0) begin n_fail++; $display("FAIL abort_rem got=%h exp=0", remainder_o); end
    n_cmp++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL abort_zero got=%b exp=1", zero_o); end
    n_cmp++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL abort_dz got=%b exp=0", div_zero_o); end
    rst_i = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (done_o || busy_o) done_cnt++;
    end
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done active_cycles=%0d exp=0", done_cnt); end
    do_start(1'b0, 32'd100, 32'd7);
    wait_done(lat, bn);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL after_abort_latency got=%0d exp=33", lat); end
    n_cmp++; if (quotient_o !== 32'd14) begin n_fail++; $display("FAIL after_abort_quot got=%h exp=e", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd2) begin n_fail++; $display("FAIL after_abort_rem got=%h exp=2", remainder_o); end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back_start();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
